// File: rtl/draw_pkg.sv
// Shared types and VGA geometry for the draw scheduler and its arbiter.
package draw_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } draw_state_e;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

endpackage

// File: rtl/draw_arbiter.sv
// Combinational winner pick: first requester found when scanning upward from ptr, wrapping.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   idx,
  output logic             valid
);

  always_comb begin
    int cand;
    cand  = 0;
    idx   = '0;
    valid = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Grants the single VGA write port to one draw engine at a time.
// Define DRAW_SCHEDULER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int IDW        = 2,
  parameter int MAX_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  input  logic [N_REQ*8-1:0] x_in,
  input  logic [N_REQ*7-1:0] y_in,
  input  logic [N_REQ*3-1:0] c_in,
  input  logic [N_REQ-1:0]   plot_in,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   start,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [C_W-1:0]     c_out,
  output logic               plot_out,
  output logic               busy,
  output logic [IDW-1:0]     active_id,
  output logic               timeout_err
);

  localparam int WD_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  draw_state_e      state, next_state;
  logic [WD_W-1:0]  wd;
  logic [IDW-1:0]   win_id;
  logic             win_valid;
  logic [IDW-1:0]   ptr;
  logic [N_REQ-1:0] sel_onehot;
  logic             plot_r;
  logic             timeout_hit;

  draw_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arbiter (
    .req   (req),
    .ptr   (ptr),
    .idx   (win_id),
    .valid (win_valid)
  );

`ifdef DRAW_SCHEDULER_ROUND_ROBIN_EN
  logic [IDW-1:0] rr_ptr;

  // Pointer holds the next search start, so after reset the scan begins at engine 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == S_IDLE && win_valid) begin
      rr_ptr <= (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    end
  end

  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  assign sel_onehot = N_REQ'(1) << active_id;

  // A dropped req counts like done; done beats the watchdog on the limit cycle.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    grant       = '0;
    start       = '0;
    busy        = 1'b1;
    plot_out    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (win_valid) next_state = S_START;
      end
      S_START: begin
        grant      = sel_onehot;
        start      = sel_onehot;
        next_state = S_BUSY;
      end
      S_BUSY: begin
        grant    = sel_onehot;
        plot_out = plot_r;
        if (done[active_id] || !req[active_id]) begin
          next_state = S_RELEASE;
        end else if (wd == WD_W'(MAX_CYCLES - 1)) begin
          next_state  = S_RELEASE;
          timeout_hit = 1'b1;
        end
      end
      S_RELEASE: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      active_id   <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
      plot_r      <= 1'b0;
      x_out       <= '0;
      y_out       <= '0;
      c_out       <= '0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && win_valid) active_id <= win_id;
      if (state == S_START)     wd <= '0;
      else if (state == S_BUSY) wd <= wd + 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
      // Only the owner's strobe is ever captured; others never reach the VGA port.
      plot_r <= (state == S_BUSY) && plot_in[active_id];
      if (state == S_BUSY) begin
        x_out <= x_in[int'(active_id)*X_W +: X_W];
        y_out <= y_in[int'(active_id)*Y_W +: Y_W];
        c_out <= c_in[int'(active_id)*C_W +: C_W];
      end
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scenario bench for draw_scheduler (MAX_CYCLES=16); expects round-robin order when
// DRAW_SCHEDULER_ROUND_ROBIN_EN is defined, fixed priority otherwise.
module tb_draw_scheduler;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int MAX = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, done, plot_in;
  logic [N*8-1:0] x_in;
  logic [N*7-1:0] y_in;
  logic [N*3-1:0] c_in;
  logic [N-1:0] grant, start;
  logic [7:0]   x_out;
  logic [6:0]   y_out;
  logic [2:0]   c_out;
  logic         plot_out, busy, timeout_err;
  logic [IDW-1:0] active_id;

  int n_cmp = 0;
  int n_bad = 0;
  logic [17:0] pix_q[$];
  int          id_q[$];

  draw_scheduler #(.N_REQ(N), .IDW(IDW), .MAX_CYCLES(MAX)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .c_in(c_in), .plot_in(plot_in),
    .grant(grant), .start(start), .x_out(x_out), .y_out(y_out), .c_out(c_out),
    .plot_out(plot_out), .busy(busy), .active_id(active_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_engine(input int e, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    x_in[e*8 +: 8] = x;
    y_in[e*7 +: 7] = y;
    c_in[e*3 +: 3] = c;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = '0; done = '0; plot_in = '0;
    x_in = '0; y_in = '0; c_in = '0;
    tick();
    reset = 1'b0;
  endtask

  // Returns the index of a one-hot start pulse that matches grant, -2 for a malformed pulse, -1 on timeout.
  task automatic wait_start(output int id);
    id = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (start != '0) begin
        id = -2;
        for (int i = 0; i < N; i++)
          if (start == (N'(1) << i) && grant == start) id = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0; done = '0; plot_in = '0;
    x_in = '1; y_in = '1; c_in = '1;
    tick();
    tick();
    n_cmp++;
    if ({grant, start, plot_out, busy, active_id, timeout_err, x_out, y_out, c_out} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got grant=%b start=%b plot=%b busy=%b id=%0d terr=%b xyc=%0d/%0d/%0d, expected all zero",
               grant, start, plot_out, busy, active_id, timeout_err, x_out, y_out, c_out);
    end
    apply_reset();
  endtask

  task automatic test_single_plot();
    int id;
    logic [17:0] exp_pix;
    req = 4'b0001;
    wait_start(id);
    n_cmp++;
    if (id !== 0) begin n_bad++; $display("[TB] FAIL t1_start: got id %0d expected 0", id); end
    n_cmp++;
    if ({busy, plot_out} !== 2'b10) begin n_bad++; $display("[TB] FAIL t1_start_status: got busy/plot %b%b expected 10", busy, plot_out); end
    tick();
    n_cmp++;
    if ({start, plot_out} !== 5'b0000_0) begin n_bad++; $display("[TB] FAIL t1_busy_first: got start=%b plot=%b expected 0000/0", start, plot_out); end
    set_engine(0, 8'd5, 7'd7, 3'd3);
    plot_in = 4'b0001;
    pix_q.push_back({8'd5, 7'd7, 3'd3});
    tick();
    exp_pix = pix_q.pop_front();
    n_cmp++;
    if (plot_out !== 1'b1 || {x_out, y_out, c_out} !== exp_pix) begin
      n_bad++;
      $display("[TB] FAIL t1_pixel: got plot=%b xyc=%0d/%0d/%0d expected 1 %0d/%0d/%0d",
               plot_out, x_out, y_out, c_out, exp_pix[17:10], exp_pix[9:3], exp_pix[2:0]);
    end
    plot_in = '0;
    done = 4'b0001;
    tick();
    n_cmp++;
    if ({grant, plot_out, busy} !== 6'b0000_0_1) begin
      n_bad++; $display("[TB] FAIL t1_release: got grant=%b plot=%b busy=%b expected 0000/0/1", grant, plot_out, busy);
    end
    done = '0;
    req = '0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL t1_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_priority_pair();
    int id, exp_id;
    id_q.push_back(1);
    id_q.push_back(2);
    req = 4'b0110;
    for (int k = 0; k < 2; k++) begin
      wait_start(id);
      exp_id = id_q.pop_front();
      n_cmp++;
      if (id !== exp_id) begin n_bad++; $display("[TB] FAIL t2_order%0d: got id %0d expected %0d", k, id, exp_id); end
      tick();
      if (id >= 0) begin
        done = N'(1) << id;
        req  = req & ~(N'(1) << id);
      end
      tick();
      done = '0;
      n_cmp++;
      if ({grant, busy} !== 5'b0000_1) begin n_bad++; $display("[TB] FAIL t2_release%0d: got grant=%b busy=%b expected 0000/1", k, grant, busy); end
      tick();
      n_cmp++;
      if ({grant, busy} !== 5'b0000_0) begin n_bad++; $display("[TB] FAIL t2_gap%0d: got grant=%b busy=%b expected 0000/0", k, grant, busy); end
    end
  endtask

  task automatic test_held_all();
    int id, exp_id;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
`ifdef DRAW_SCHEDULER_ROUND_ROBIN_EN
      id_q.push_back(k % N);
`else
      id_q.push_back(0);
`endif
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(id);
      exp_id = id_q.pop_front();
      n_cmp++;
      if (id !== exp_id) begin n_bad++; $display("[TB] FAIL t3_order%0d: got id %0d expected %0d", k, id, exp_id); end
      tick();
      if (id >= 0) done = N'(1) << id;
      tick();
      done = '0;
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    int id, cnt;
    apply_reset();
    req = 4'b0001;
    wait_start(id);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (grant == '0) break;
      cnt++;
      if (cnt == MAX) begin
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_bad++; $display("[TB] FAIL t4_err_early: got %b expected 0", timeout_err); end
      end
    end
    n_cmp++;
    if (cnt !== MAX) begin n_bad++; $display("[TB] FAIL t4_busy_len: got %0d cycles expected %0d", cnt, MAX); end
    n_cmp++;
    if ({busy, timeout_err} !== 2'b11) begin n_bad++; $display("[TB] FAIL t4_timeout: got busy/terr %b%b expected 11", busy, timeout_err); end
    req = '0;
    apply_reset();
    req = 4'b0001;
    wait_start(id);
    for (int k = 0; k < MAX; k++) tick();
    n_cmp++;
    if (grant !== 4'b0001) begin n_bad++; $display("[TB] FAIL t4_limit_owner: got grant %b expected 0001", grant); end
    done = 4'b0001;
    tick();
    done = '0;
    req = '0;
    n_cmp++;
    if ({grant, timeout_err} !== 5'b0000_0) begin n_bad++; $display("[TB] FAIL t4_done_wins: got grant=%b terr=%b expected 0000/0", grant, timeout_err); end
    tick();
  endtask

  task automatic test_early_release();
    int id;
    apply_reset();
    req = 4'b0010;
    wait_start(id);
    tick();
    tick();
    n_cmp++;
    if ({grant, active_id} !== 6'b0010_01) begin n_bad++; $display("[TB] FAIL t_early_owner: got grant=%b id=%0d expected 0010/1", grant, active_id); end
    req = '0;
    tick();
    n_cmp++;
    if ({grant, busy, timeout_err} !== 6'b0000_1_0) begin n_bad++; $display("[TB] FAIL t_early_release: got grant=%b busy=%b terr=%b expected 0000/1/0", grant, busy, timeout_err); end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL t_early_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_isolation();
    int id;
    logic [17:0] exp_pix;
    apply_reset();
    req = 4'b1001;
    wait_start(id);
    n_cmp++;
    if (id !== 0) begin n_bad++; $display("[TB] FAIL t5_owner: got id %0d expected 0", id); end
    tick();
    set_engine(3, 8'd99, 7'd50, 3'd6);
    plot_in = 4'b1000;
    tick();
    n_cmp++;
    if (plot_out !== 1'b0) begin n_bad++; $display("[TB] FAIL t5_foreign_plot: got plot %b expected 0", plot_out); end
    set_engine(0, 8'd10, 7'd20, 3'd5);
    plot_in = 4'b1001;
    pix_q.push_back({8'd10, 7'd20, 3'd5});
    tick();
    exp_pix = pix_q.pop_front();
    n_cmp++;
    if (plot_out !== 1'b1 || {x_out, y_out, c_out} !== exp_pix) begin
      n_bad++;
      $display("[TB] FAIL t5_pixel: got plot=%b xyc=%0d/%0d/%0d expected 1 %0d/%0d/%0d",
               plot_out, x_out, y_out, c_out, exp_pix[17:10], exp_pix[9:3], exp_pix[2:0]);
    end
    plot_in = '0;
    done = 4'b1000;
    tick();
    done = '0;
    tick();
    n_cmp++;
    if (grant !== 4'b0001) begin n_bad++; $display("[TB] FAIL t5_foreign_done: got grant %b expected 0001", grant); end
    done = 4'b0001;
    req = 4'b1000;
    tick();
    done = '0;
    n_cmp++;
    if (grant !== 4'b0000) begin n_bad++; $display("[TB] FAIL t5_release: got grant %b expected 0000", grant); end
    wait_start(id);
    n_cmp++;
    if (id !== 3) begin n_bad++; $display("[TB] FAIL t5_next_owner: got id %0d expected 3", id); end
  endtask

  task automatic test_reset_busy();
    int id;
    apply_reset();
    req = 4'b0100;
    wait_start(id);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (grant == '0) break;
    end
    n_cmp++;
    if (timeout_err !== 1'b1) begin n_bad++; $display("[TB] FAIL t6_terr_set: got %b expected 1", timeout_err); end
    wait_start(id);
    tick();
    set_engine(2, 8'd33, 7'd44, 3'd2);
    plot_in = 4'b0100;
    tick();
    n_cmp++;
    if ({plot_out, grant} !== 5'b1_0100) begin n_bad++; $display("[TB] FAIL t6_pre_reset: got plot=%b grant=%b expected 1/0100", plot_out, grant); end
    reset = 1'b1;
    plot_in = '0;
    tick();
    reset = 1'b0;
    req = '0;
    n_cmp++;
    if ({grant, plot_out, busy, timeout_err, active_id} !== 9'b0) begin
      n_bad++;
      $display("[TB] FAIL t6_reset_busy: got grant=%b plot=%b busy=%b terr=%b id=%0d expected all zero",
               grant, plot_out, busy, timeout_err, active_id);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL t6_no_release: got busy %b expected 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    req = '0; done = '0; plot_in = '0;
    x_in = '0; y_in = '0; c_in = '0;
    $display("[TB] starting draw_scheduler bench");
    test_reset();
    test_single_plot();
    test_priority_pair();
    test_held_all();
    test_watchdog();
    test_early_release();
    test_isolation();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
